// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the oversampling UART receiver: parity-mode
// encodings, receiver FSM state type and a small parity helper.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_HIGH
    } rx_state_t;

    // Mode 3 is treated the same as PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-word handshake between the UART receiver (master) and its
// consumer (slave): word, flags, valid/ready and the overrun pulse.
interface uart_rx_os_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_error;
    logic                 stopbit_error;
    logic                 overrun;

    modport master (
        output data_out,
        output data_valid,
        output parity_error,
        output stopbit_error,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  stopbit_error,
        input  overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_os_baud_tick.sv
// Oversampling tick generator: one-cycle tick every div+1 clocks.
// While clear is high the count is held at zero, so the first tick after
// clear drops arrives div+1 cycles after the last cleared cycle.
module uart_baud_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = !clear && (cnt == div);

    // Free-running divider counter, restarted by clear or on each tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, restartable tick
// generator, frame FSM (start/data/parity/stop) and a one-deep output
// register with valid/ready handshake and overrun reporting.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        baud_div,
    input  logic [1:0]         parity_mode,
    input  logic               two_stop,
    input  logic               rx_i,
    output logic               busy,
    uart_rx_os_if.master       rx_if
);

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_sync;
    rx_state_t            state;
    rx_state_t            state_n;
    logic [15:0]          div_q;
    logic [1:0]           pmode_q;
    logic                 two_stop_q;
    logic [OS_W-1:0]      os_cnt;
    logic [OS_W-1:0]      os_cnt_n;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_n;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_n;
    logic                 perr_q;
    logic                 perr_n;
    logic                 serr_q;
    logic                 serr_n;
    logic                 tick;
    logic                 bit_tick;
    logic                 start_det;
    logic                 frame_done;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    uart_baud_tick u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .div   (div_q),
        .tick  (tick)
    );

    assign busy     = (state != IDLE);
    // Start bit is sampled at its middle; every later bit one full bit on.
    assign bit_tick = tick && (os_cnt == ((state == START) ? OS_HALF : OS_LAST));

    // Next-state logic: frame sequencing, shifting and error accumulation.
    always_comb begin
        state_n    = state;
        os_cnt_n   = os_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift_q;
        perr_n     = perr_q;
        serr_n     = serr_q;
        start_det  = 1'b0;
        frame_done = 1'b0;

        if (tick) begin
            os_cnt_n = bit_tick ? '0 : os_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                os_cnt_n  = '0;
                bit_cnt_n = '0;
                perr_n    = 1'b0;
                serr_n    = 1'b0;
                if (!rx_sync) begin
                    start_det = 1'b1;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_n = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_n = {rx_sync, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = parity_enabled(pmode_q) ? PARITY : STOP1;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    if (pmode_q == PAR_ODD) begin
                        perr_n = ~((^shift_q) ^ rx_sync);
                    end else begin
                        perr_n = (^shift_q) ^ rx_sync;
                    end
                    state_n = STOP1;
                end
            end
            STOP1: begin
                if (bit_tick) begin
                    serr_n = serr_q | ~rx_sync;
                    if (two_stop_q) begin
                        state_n = STOP2;
                    end else begin
                        frame_done = 1'b1;
                        state_n    = rx_sync ? IDLE : WAIT_HIGH;
                    end
                end
            end
            STOP2: begin
                if (bit_tick) begin
                    serr_n     = serr_q | ~rx_sync;
                    frame_done = 1'b1;
                    state_n    = rx_sync ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_sync) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM state, per-frame datapath and frame configuration latched at start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            div_q      <= '0;
            pmode_q    <= PAR_NONE;
            two_stop_q <= 1'b0;
        end else begin
            state   <= state_n;
            os_cnt  <= os_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift_q <= shift_n;
            perr_q  <= perr_n;
            serr_q  <= serr_n;
            if (start_det) begin
                div_q      <= baud_div;
                pmode_q    <= parity_mode;
                two_stop_q <= two_stop;
            end
        end
    end

    // Output holding register: load when free or being drained, else drop
    // the frame and pulse overrun; a load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_if.data_out      <= '0;
            rx_if.data_valid    <= 1'b0;
            rx_if.parity_error  <= 1'b0;
            rx_if.stopbit_error <= 1'b0;
            rx_if.overrun       <= 1'b0;
        end else begin
            rx_if.overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_if.data_valid || rx_if.data_ready) begin
                    rx_if.data_out      <= shift_q;
                    rx_if.parity_error  <= perr_q;
                    rx_if.stopbit_error <= serr_n;
                    rx_if.data_valid    <= 1'b1;
                end else begin
                    rx_if.overrun <= 1'b1;
                end
            end else if (rx_if.data_valid && rx_if.data_ready) begin
                rx_if.data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, ticks per bit; even values only, minimum 8.
REQ-003 Port clk  input  1  sole clock; all flops rising-edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port baud_div  input  16  tick period minus one, in clk cycles.
REQ-006 Port parity_mode  input  2  0 none, 1 even, 2 odd, 3 treated as none.
REQ-007 Port two_stop  input  1  1 selects two stop bits.
REQ-008 Port rx_i  input  1  serial line; idles high; asynchronous to clk.
REQ-009 Port data_out  output  DATA_BITS  received word, LSB first on the line.
REQ-010 Port data_valid  output  1  data_out and error flags are valid.
REQ-011 Port data_ready  input  1  consumer accepts data when data_valid=1.
REQ-012 Port parity_error  output  1  parity mismatch for the word held on data_out.
REQ-013 Port stopbit_error  output  1  a stop bit was sampled 0 for the held word.
REQ-014 Port overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-015 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 rx_i SHALL pass through a 2-flop synchroniser whose flops reset to 1; the FSM uses only the synchronised value.
REQ-017 The tick generator SHALL pulse for one clk every baud_div+1 cycles; baud_div=0 gives a tick every cycle.
REQ-018 The tick generator SHALL restart its count at start detection, so the first tick occurs baud_div+1 cycles later.
REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2 and WAIT_HIGH.
REQ-020 IDLE -> START when the synchronised line reads 0; baud_div, parity_mode and two_stop SHALL be latched at that point and held for the frame.
REQ-021 START: on tick OVERSAMPLE/2 the line SHALL be sampled; 1 returns to IDLE (glitch rejected, nothing reported), 0 moves to DATA.
REQ-022 DATA: one bit SHALL be sampled every OVERSAMPLE ticks and shifted in LSB first; after DATA_BITS bits the FSM goes to PARITY if parity is enabled, else to STOP1.
REQ-023 PARITY: the line SHALL be sampled once; parity_error is set if (XOR of data ^ bit) != 0 for even parity, or == 0 for odd parity.
REQ-024 STOP1 and STOP2 SHALL each sample once; any 0 sets stopbit_error; STOP1 goes to STOP2 only when two_stop was latched.
REQ-025 Frame completion SHALL occur on the final stop-bit sample tick; the exit is WAIT_HIGH if the sampled line is 0, else IDLE.
REQ-026 WAIT_HIGH SHALL hold until the synchronised line reads 1 and then go to IDLE, so a break condition yields exactly one frame.
REQ-027 At completion, if data_valid=0 or data_ready=1, data_out and both error flags SHALL load and data_valid SHALL be 1 on the next cycle.
REQ-028 At completion, if data_valid=1 and data_ready=0, the new frame SHALL be discarded, data_out and the flags held, and overrun pulsed for one cycle.
REQ-029 data_valid SHALL clear on the cycle after data_valid and data_ready are both 1, unless a frame loads in that same cycle.
REQ-030 A frame that has errors SHALL still be delivered with its flags; flags are meaningful only while data_valid=1.

Reset
REQ-031 While rst=0: FSM in IDLE, counters 0, synchroniser 1, data_out 0, data_valid 0, parity_error 0, stopbit_error 0, overrun 0, busy 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no output; after release the next start SHALL be detected normally.

Structure
REQ-033 Shared package uart_pkg SHALL hold the parity-mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state typedef.
REQ-034 The tick generator SHALL be the sub-module uart_baud_tick (inputs clk, rst, clear, div; output tick).

Verification
REQ-035 DATA_BITS=8, OVERSAMPLE=16, baud_div=3 (64 clk/bit), even parity, send 8'h69 with parity 0 -> data_out=8'h69, data_valid=1, both error flags 0.
REQ-036 Same setup, odd parity, send 8'h69 with parity bit 0 -> data_out=8'h69, parity_error=1.
REQ-037 Stop bit driven 0, line then held low 500 clk -> one frame with stopbit_error=1, no further frame until rx_i returns high.
REQ-038 rx_i low for 20 clk only -> no data_valid, busy returns to 0.
REQ-039 Two frames (8'hA5, 8'h3C) with data_ready=0 -> data_out stays 8'hA5, one overrun pulse; raising data_ready on the second frame's completion cycle loads 8'h3C with no overrun.
REQ-040 rst low in the middle of a DATA bit, then a clean 8'h55 frame -> only 8'h55 is reported.
